// File: rtl/driver_teclado_matriz_if.sv
// Keypad event handshake bundle: key code plus valid/ready between the scanner (master) and its consumer (slave).
// Latency: none, wires only.
// Backpressure: the master holds digito/tecla_valid until it sees tecla_ready.
interface driver_teclado_matriz_if #(
  parameter int CODE_W = 4
);
  logic [CODE_W-1:0] digito;
  logic              tecla_valid;
  logic              tecla_ready;

  modport master (output digito, output tecla_valid, input tecla_ready);
  modport slave  (input digito, input tecla_valid, output tecla_ready);
endinterface

// File: rtl/driver_teclado_matriz.sv
// Matrix keypad scanner: one-hot column drive, 2-FF row synchroniser, press/release debounce, one-event output buffer.
// Latency: event valid the cycle after the DEB_CNT-th consecutive pressed sample (rows seen 2 cycles late).
// Backpressure: one buffered event; an event arriving while valid&&!ready is dropped and sets sticky overflow.
// Optional auto-repeat while held: define TECLADO_REPEAT_EN (REP_DELAY / REP_RATE used only then).
module driver_teclado_matriz #(
  parameter int N_FILA    = 4,
  parameter int N_COL     = 4,
  parameter int SCAN_DIV  = 1000,
  parameter int DEB_CNT   = 20000,
  parameter int REP_DELAY = 5000000,
  parameter int REP_RATE  = 1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_FILA-1:0]       fila,
  output logic [N_COL-1:0]        col,
  driver_teclado_matriz_if.master tec,
  output logic                    tecla_activa,
  output logic                    overflow
);
  localparam int CODE_W = (N_FILA * N_COL > 1) ? $clog2(N_FILA * N_COL) : 1;
  localparam int CI_W   = (N_COL > 1) ? $clog2(N_COL) : 1;
  localparam int RI_W   = (N_FILA > 1) ? $clog2(N_FILA) : 1;
  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam int DEB_W  = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;

  typedef enum logic [1:0] {S_SCAN, S_CONFIRM, S_PRESSED} estado_t;

  estado_t             estado, estado_n;
  logic [N_FILA-1:0]   fs1, fs;
  logic [CI_W-1:0]     col_idx, col_idx_n, col_sig;
  logic [RI_W-1:0]     fila_idx, fila_idx_n, low_idx;
  logic [DIV_W-1:0]    div_cnt, div_cnt_n;
  logic [DEB_W-1:0]    deb_cnt, deb_cnt_n;
  logic                fs_r;
  logic                emit, emit_rep, emit_all;
  logic [CODE_W-1:0]   codigo, dig_q;
  logic                valid_q;

  // Two-stage synchroniser for the asynchronous row inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      fs1 <= '0;
      fs  <= '0;
    end else begin
      fs1 <= fila;
      fs  <= fs1;
    end
  end

  // Column drive, next column, lowest active row, tracked-row level and key code.
  always_comb begin
    col          = '0;
    col[col_idx] = 1'b1;
    col_sig      = (col_idx == CI_W'(N_COL - 1)) ? '0 : col_idx + 1'b1;
    low_idx      = '0;
    for (int i = N_FILA - 1; i >= 0; i--) begin
      if (fs[i]) low_idx = RI_W'(i);
    end
    fs_r   = fs[fila_idx];
    codigo = CODE_W'(fila_idx) * CODE_W'(N_COL) + CODE_W'(col_idx);
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado   <= S_SCAN;
      col_idx  <= '0;
      fila_idx <= '0;
      div_cnt  <= '0;
      deb_cnt  <= '0;
    end else begin
      estado   <= estado_n;
      col_idx  <= col_idx_n;
      fila_idx <= fila_idx_n;
      div_cnt  <= div_cnt_n;
      deb_cnt  <= deb_cnt_n;
    end
  end

  // Scan / confirm / held sequencing; column stays frozen outside SCAN.
  always_comb begin
    estado_n   = estado;
    col_idx_n  = col_idx;
    fila_idx_n = fila_idx;
    div_cnt_n  = div_cnt;
    deb_cnt_n  = deb_cnt;
    emit       = 1'b0;
    case (estado)
      S_SCAN: begin
        if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
          div_cnt_n = '0;
          if (fs != '0) begin
            fila_idx_n = low_idx;
            deb_cnt_n  = '0;
            estado_n   = S_CONFIRM;
          end else begin
            col_idx_n = col_sig;
          end
        end else begin
          div_cnt_n = div_cnt + 1'b1;
        end
      end
      S_CONFIRM: begin
        if (fs_r) begin
          if (deb_cnt == DEB_W'(DEB_CNT - 1)) begin
            emit      = 1'b1;
            deb_cnt_n = '0;
            estado_n  = S_PRESSED;
          end else begin
            deb_cnt_n = deb_cnt + 1'b1;
          end
        end else begin
          deb_cnt_n = '0;
          col_idx_n = col_sig;
          estado_n  = S_SCAN;
        end
      end
      S_PRESSED: begin
        if (fs_r) begin
          deb_cnt_n = '0;
        end else if (deb_cnt == DEB_W'(DEB_CNT - 1)) begin
          deb_cnt_n = '0;
          col_idx_n = col_sig;
          estado_n  = S_SCAN;
        end else begin
          deb_cnt_n = deb_cnt + 1'b1;
        end
      end
      default: estado_n = S_SCAN;
    endcase
  end

`ifdef TECLADO_REPEAT_EN
  localparam int REP_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

  logic [REP_W-1:0] hold_cnt, hold_n, rep_lim;
  logic             rep_on, rep_on_n;

  // Hold timer: first repeat after REP_DELAY held cycles, then every REP_RATE; any release sample restarts it.
  always_comb begin
    hold_n   = hold_cnt;
    rep_on_n = rep_on;
    emit_rep = 1'b0;
    rep_lim  = rep_on ? REP_W'(REP_RATE - 1) : REP_W'(REP_DELAY - 1);
    if (estado == S_PRESSED && fs_r) begin
      if (hold_cnt == rep_lim) begin
        emit_rep = 1'b1;
        hold_n   = '0;
        rep_on_n = 1'b1;
      end else begin
        hold_n = hold_cnt + 1'b1;
      end
    end else begin
      hold_n   = '0;
      rep_on_n = 1'b0;
    end
  end

  // Hold timer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      rep_on   <= 1'b0;
    end else begin
      hold_cnt <= hold_n;
      rep_on   <= rep_on_n;
    end
  end
`else
  // Repeat disabled: never true for legal parameters, keeps REP_* referenced.
  assign emit_rep = (REP_DELAY < 0) && (REP_RATE < 0);
`endif

  assign emit_all = emit | emit_rep;

  // One-deep event buffer: a free slot or same-cycle accept takes the new code, otherwise it is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      dig_q    <= '0;
      valid_q  <= 1'b0;
      overflow <= 1'b0;
    end else if (emit_all) begin
      if (!valid_q || tec.tecla_ready) begin
        dig_q   <= codigo;
        valid_q <= 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end else if (valid_q && tec.tecla_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign tec.digito      = dig_q;
  assign tec.tecla_valid = valid_q;
  assign tecla_activa    = (estado == S_PRESSED);
endmodule

// File: tb/tb_driver_teclado_matriz.sv
// Directed bench for driver_teclado_matriz with a small keypad model (closed keys route driven columns onto rows).
// Latency: checks sampled on the falling edge.
// Backpressure: tecla_ready driven per scenario; repeat scenario follows TECLADO_REPEAT_EN.
module tb_driver_teclado_matriz;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  fila;
  logic [3:0]  col;
  logic        tecla_activa;
  logic        overflow;
  logic [15:0] keys;
  logic        frc_en;
  logic [3:0]  frc_val;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  driver_teclado_matriz_if #(.CODE_W(4)) tec ();

  driver_teclado_matriz #(
    .N_FILA(4), .N_COL(4), .SCAN_DIV(4), .DEB_CNT(8), .REP_DELAY(40), .REP_RATE(16)
  ) dut (
    .clk(clk), .rst(rst), .fila(fila), .col(col), .tec(tec),
    .tecla_activa(tecla_activa), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Cycle counter for measuring event spacing.
  always @(posedge clk) cyc <= cyc + 1;

  // Keypad model: key r*4+c closes row r onto column c; frc_en overrides the rows directly.
  always_comb begin
    fila = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && col[c]) fila[r] = 1'b1;
    if (frc_en) fila = frc_val;
  end

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tec.tecla_valid === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_activa(input logic lvl, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tecla_activa === lvl) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_col(input logic [3:0] c, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (col === c) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    logic [3:0] exp;
    rst = 1'b1; keys = '0; frc_en = 1'b0; frc_val = '0; tec.tecla_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (col !== 4'b0001) begin errors++; $display("FAIL reset_col got %b want 0001", col); end
    checks++; if (tec.tecla_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", tec.tecla_valid); end
    checks++; if (tec.digito !== 4'd0) begin errors++; $display("FAIL reset_digito got %0d want 0", tec.digito); end
    checks++; if (tecla_activa !== 1'b0) begin errors++; $display("FAIL reset_activa got %b want 0", tecla_activa); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      exp = 4'b0001 << ((i / 4) % 4);
      checks++; if (col !== exp) begin errors++; $display("FAIL scan_walk[%0d] got %b want %b", i, col, exp); end
    end
    checks++; if (tec.tecla_valid !== 1'b0 || tecla_activa !== 1'b0) begin
      errors++; $display("FAIL scan_idle got valid=%b activa=%b want 0 0", tec.tecla_valid, tecla_activa); end
  endtask

  task automatic test_press;
    bit ok;
    int nev;
    tec.tecla_ready = 1'b1;
    keys = '0; keys[9] = 1'b1;
    wait_valid(ok);
    nev = ok ? 1 : 0;
    checks++; if (!ok) begin errors++; $display("FAIL press_event got none want digito 9"); end
    checks++; if (tec.digito !== 4'd9) begin errors++; $display("FAIL press_digito got %0d want 9", tec.digito); end
    checks++; if (tecla_activa !== 1'b1) begin errors++; $display("FAIL press_activa got %b want 1", tecla_activa); end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tec.tecla_valid === 1'b1) nev++;
    end
    keys = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (tec.tecla_valid === 1'b1) nev++;
      if (k == 9) begin
        checks++; if (tecla_activa !== 1'b1) begin errors++; $display("FAIL release_hold got activa=%b want 1 at 9 cycles", tecla_activa); end
      end
      if (k == 10) begin
        checks++; if (tecla_activa !== 1'b0) begin errors++; $display("FAIL release_drop got activa=%b want 0 at 10 cycles", tecla_activa); end
      end
    end
    checks++; if (nev != 1) begin errors++; $display("FAIL press_count got %0d events want 1", nev); end
  endtask

  task automatic test_bounce;
    bit ok;
    int nev = 0;
    wait_col(4'b1000, ok);
    wait_col(4'b0001, ok);
    frc_en = 1'b1; frc_val = 4'b0001;
    repeat (3) @(negedge clk);
    frc_val = 4'b0000;
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (col !== 4'b0001) begin ok = 1'b1; break; end
    end
    checks++; if (!ok || col !== 4'b0010) begin errors++; $display("FAIL bounce_next_col got %b want 0010", col); end
    frc_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tec.tecla_valid === 1'b1) nev++;
    end
    checks++; if (nev != 0) begin errors++; $display("FAIL bounce_event got %0d events want 0", nev); end
    checks++; if (overflow !== 1'b0 || tecla_activa !== 1'b0) begin
      errors++; $display("FAIL bounce_flags got ovf=%b activa=%b want 0 0", overflow, tecla_activa); end
  endtask

  task automatic test_overflow;
    bit ok;
    tec.tecla_ready = 1'b0;
    keys = '0; keys[0] = 1'b1;
    wait_valid(ok);
    checks++; if (!ok || tec.digito !== 4'd0) begin errors++; $display("FAIL ovf_first got ok=%b digito=%0d want 1 0", ok, tec.digito); end
    keys = '0;
    wait_activa(1'b0, ok);
    keys[15] = 1'b1;
    wait_activa(1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_second_press got none want confirm of key 15"); end
    checks++; if (tec.tecla_valid !== 1'b1 || tec.digito !== 4'd0) begin
      errors++; $display("FAIL ovf_held got valid=%b digito=%0d want 1 0", tec.tecla_valid, tec.digito); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
    keys = '0;
    wait_activa(1'b0, ok);
    tec.tecla_ready = 1'b1;
    @(negedge clk);
    checks++; if (tec.tecla_valid !== 1'b0) begin errors++; $display("FAIL ovf_drain got valid=%b want 0", tec.tecla_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
  endtask

  task automatic test_lowest_row_and_reset;
    bit ok;
    int nev = 0;
    tec.tecla_ready = 1'b1;
    keys = '0; keys[4] = 1'b1; keys[12] = 1'b1;
    wait_valid(ok);
    checks++; if (!ok || tec.digito !== 4'd4) begin errors++; $display("FAIL lowest_row got ok=%b digito=%0d want 1 4", ok, tec.digito); end
    keys = '0;
    wait_activa(1'b0, ok);
    wait_col(4'b0001, ok);
    keys[9] = 1'b1;
    wait_col(4'b0010, ok);
    repeat (6) @(negedge clk);
    checks++; if (col !== 4'b0010 || tec.tecla_valid !== 1'b0) begin
      errors++; $display("FAIL confirm_frozen got col=%b valid=%b want 0010 0", col, tec.tecla_valid); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (col !== 4'b0001) begin errors++; $display("FAIL midrst_col got %b want 0001", col); end
    checks++; if (tec.tecla_valid !== 1'b0 || tecla_activa !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL midrst_flags got valid=%b activa=%b ovf=%b want 0 0 0", tec.tecla_valid, tecla_activa, overflow); end
    @(negedge clk);
    rst = 1'b0; keys = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tec.tecla_valid === 1'b1) nev++;
    end
    checks++; if (nev != 0) begin errors++; $display("FAIL midrst_discard got %0d events want 0", nev); end
  endtask

  task automatic test_repeat;
    int ev_t[8];
    int n = 0;
    int first_t = 0;
    bit released = 1'b0;
    bit done = 1'b0;
    tec.tecla_ready = 1'b1;
    keys = '0; keys[5] = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (tec.tecla_valid === 1'b1) begin
        checks++; if (tec.digito !== 4'd5) begin errors++; $display("FAIL repeat_digito[%0d] got %0d want 5", n, tec.digito); end
        if (n == 0) first_t = cyc;
        if (n < 8) ev_t[n] = cyc;
        n++;
      end
      if (n > 0 && !released && (cyc - first_t) >= 100) begin keys = '0; released = 1'b1; end
      if (released && tecla_activa === 1'b0) begin done = 1'b1; break; end
    end
    checks++; if (!done) begin errors++; $display("FAIL repeat_timeout got no release want activa low"); end
`ifdef TECLADO_REPEAT_EN
    checks++; if (n != 5) begin errors++; $display("FAIL repeat_count got %0d want 5", n); end
    if (n >= 5) begin
      checks++; if (ev_t[1] - ev_t[0] != 40) begin errors++; $display("FAIL repeat_first got %0d want 40", ev_t[1] - ev_t[0]); end
      for (int k = 2; k < 5; k++) begin
        checks++; if (ev_t[k] - ev_t[k-1] != 16) begin errors++; $display("FAIL repeat_rate[%0d] got %0d want 16", k, ev_t[k] - ev_t[k-1]); end
      end
    end
`else
    checks++; if (n != 1) begin errors++; $display("FAIL single_event got %0d want 1", n); end
`endif
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_overflow();
    test_lowest_row_and_reset();
    test_repeat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
